button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer.sv | 124 ++++++++++++
 tb/tb_button_debouncer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Push-button debouncer: a two-flop synchronizer feeds a four-state qualify FSM.
// A new level is accepted only after it has been seen on DEBOUNCE_CYCLES
// consecutive qualify cycles. The block emits one-cycle press/release strobes
// and keeps a saturating count of qualifications abandoned because of a bounce.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ABORT_CNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       button_in,
    output logic                       button_clean,
    output logic                       press_pulse,
    output logic                       release_pulse,
    output logic [ABORT_CNT_WIDTH-1:0] abort_count
);

    // The counter only ever holds 0..DEBOUNCE_CYCLES-1, so clog2 bits are enough.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]           CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ABORT_CNT_WIDTH-1:0] ABORT_MAX = '1;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        WAIT_HIGH   = 2'b01,
        STABLE_HIGH = 2'b10,
        WAIT_LOW    = 2'b11
    } state_t;

    logic                       sync_ff;
    logic                       sync_q;
    state_t                     state;
    state_t                     state_next;
    logic [CNT_W-1:0]           count;
    logic [CNT_W-1:0]           count_next;
    logic                       abort_hit;
    logic                       clean_next;
    logic                       press_next;
    logic                       release_next;
    logic [ABORT_CNT_WIDTH-1:0] abort_next;

    // Two-flop synchronizer for the asynchronous button level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_ff <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            sync_ff <= button_in;
            sync_q  <= sync_ff;
        end
    end

    // FSM state, qualify counter and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= STABLE_LOW;
            count         <= '0;
            button_clean  <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            abort_count   <= '0;
        end else begin
            state         <= state_next;
            count         <= count_next;
            button_clean  <= clean_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            abort_count   <= abort_next;
        end
    end

    // Next-state logic; the counter advances only while staying in a WAIT state,
    // so every state change clears it.
    always_comb begin
        state_next = STABLE_LOW;
        count_next = '0;
        abort_hit  = 1'b0;
        case (state)
            STABLE_LOW: begin
                state_next = sync_q ? WAIT_HIGH : STABLE_LOW;
            end
            WAIT_HIGH: begin
                if (!sync_q) begin
                    state_next = STABLE_LOW;
                    abort_hit  = 1'b1;
                end else if (count == CNT_LAST) begin
                    state_next = STABLE_HIGH;
                end else begin
                    state_next = WAIT_HIGH;
                    count_next = count + CNT_W'(1);
                end
            end
            STABLE_HIGH: begin
                state_next = sync_q ? STABLE_HIGH : WAIT_LOW;
            end
            WAIT_LOW: begin
                if (sync_q) begin
                    state_next = STABLE_HIGH;
                    abort_hit  = 1'b1;
                end else if (count == CNT_LAST) begin
                    state_next = STABLE_LOW;
                end else begin
                    state_next = WAIT_LOW;
                    count_next = count + CNT_W'(1);
                end
            end
            default: begin
                state_next = STABLE_LOW;
            end
        endcase
    end

    // Output decode from the upcoming state so outputs switch on the transition edge.
    always_comb begin
        clean_next   = (state_next == STABLE_HIGH) || (state_next == WAIT_LOW);
        press_next   = (state == WAIT_HIGH) && (state_next == STABLE_HIGH);
        release_next = (state == WAIT_LOW) && (state_next == STABLE_LOW);
        abort_next   = abort_count;
        if (abort_hit && (abort_count != ABORT_MAX)) begin
            abort_next = abort_count + ABORT_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (DEBOUNCE_CYCLES=4, 20 ns clock).
// A run-length reference model predicts the outputs every cycle; a hand-computed
// vector table and directed sequences cover latency, bounce, reset and saturation.
module tb_button_debouncer;

    localparam int DEB       = 4;
    localparam int AW        = 8;
    localparam int ABORT_SAT = (1 << AW) - 1;

    logic          clk;
    logic          reset;
    logic          button_in;
    logic          button_clean;
    logic          press_pulse;
    logic          release_pulse;
    logic [AW-1:0] abort_count;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEB),
        .ABORT_CNT_WIDTH(AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .button_in    (button_in),
        .button_clean (button_clean),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .abort_count  (abort_count)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int press_cnt = 0;
    int rel_cnt = 0;
    int press_cyc = -1;
    bit prev_press = 1'b0;
    bit prev_rel = 1'b0;

    // Reference model: the synchronized level lags the input by two edges; the clean
    // level flips once the synchronized level has disagreed with it for DEB+1
    // consecutive edges (one detect edge plus DEB qualify edges). A disagreement
    // run that ends early counts as an abort.
    bit m_s1, m_sq, m_clean, m_press, m_rel;
    int m_run, m_abort;

    task automatic model_reset();
        m_s1 = 0; m_sq = 0; m_clean = 0; m_press = 0; m_rel = 0;
        m_run = 0; m_abort = 0;
        prev_press = 0; prev_rel = 0;
    endtask

    task automatic model_edge(input bit b);
        m_press = 0;
        m_rel   = 0;
        if (m_sq != m_clean) begin
            m_run++;
            if (m_run == DEB + 1) begin
                m_clean = m_sq;
                m_press = m_sq;
                m_rel   = !m_sq;
                m_run   = 0;
            end
        end else begin
            if (m_run > 0 && m_abort < ABORT_SAT) m_abort++;
            m_run = 0;
        end
        m_sq = m_s1;
        m_s1 = b;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    task automatic clr_stats();
        cyc = 0; press_cnt = 0; rel_cnt = 0; press_cyc = -1;
    endtask

    // Drive one input value for one clock, then compare DUT against the model on the falling edge.
    task automatic cycle(input bit b);
        button_in = b;
        @(posedge clk);
        model_edge(b);
        @(negedge clk);
        cyc++;
        check("clean",   int'(button_clean),  int'(m_clean));
        check("press",   int'(press_pulse),   int'(m_press));
        check("release", int'(release_pulse), int'(m_rel));
        check("abort",   int'(abort_count),   m_abort);
        check("pulse_excl",    int'(press_pulse && release_pulse), 0);
        check("press_double",  int'(press_pulse && prev_press), 0);
        check("release_double", int'(release_pulse && prev_rel), 0);
        prev_press = press_pulse;
        prev_rel   = release_pulse;
        if (press_pulse) begin
            press_cnt++;
            press_cyc = cyc;
        end
        if (release_pulse) rel_cnt++;
    endtask

    // Short asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        #2 reset = 1'b0;
        #1;
        check({tag, "_clean"},   int'(button_clean),  0);
        check({tag, "_press"},   int'(press_pulse),   0);
        check({tag, "_release"}, int'(release_pulse), 0);
        check({tag, "_abort"},   int'(abort_count),   0);
        #4 reset = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit b;
        bit c;
        bit p;
        bit r;
        int a;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit b, input bit c, input bit p, input bit r, input int a);
        vec_t v;
        v.b = b; v.c = c; v.p = p; v.r = r; v.a = a;
        tbl.push_back(v);
    endtask

    initial begin
        bit lvl;
        int len;

        // Hand-derived vectors: clean press, clean release, then a two-cycle glitch.
        add(0, 0, 0, 0, 0); add(0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(1, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0); add(1, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0); add(0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0); add(1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0); add(0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1); add(0, 0, 0, 0, 1);

        reset = 1'b0;
        button_in = 1'b0;
        model_reset();
        #5;
        check("reset_clean",   int'(button_clean),  0);
        check("reset_press",   int'(press_pulse),   0);
        check("reset_release", int'(release_pulse), 0);
        check("reset_abort",   int'(abort_count),   0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        // Table-driven vectors.
        clr_stats();
        foreach (tbl[i]) begin
            cycle(tbl[i].b);
            check("tbl_clean",   int'(button_clean),  int'(tbl[i].c));
            check("tbl_press",   int'(press_pulse),   int'(tbl[i].p));
            check("tbl_release", int'(release_pulse), int'(tbl[i].r));
            check("tbl_abort",   int'(abort_count),   tbl[i].a);
        end

        // Asynchronous reset while qualifying a press, then requalify from scratch.
        for (int i = 0; i < 4; i++) cycle(1);
        async_reset("rst_wait");
        clr_stats();
        for (int i = 0; i < 10; i++) cycle(1);
        check("requal_press_cnt", press_cnt, 1);
        check("requal_latency",   press_cyc, DEB + 3);

        // Asynchronous reset while stable high: no release strobe afterwards.
        async_reset("rst_high");
        clr_stats();
        for (int i = 0; i < 10; i++) cycle(0);
        check("rst_high_no_release", rel_cnt, 0);
        check("rst_high_no_press",   press_cnt, 0);

        // Bouncing press: 40 ns segments, then a stable high level.
        clr_stats();
        cycle(1); cycle(1); cycle(0); cycle(0);
        cycle(1); cycle(1); cycle(0); cycle(0);
        check("bounce_no_press", press_cnt, 0);
        check("bounce_aborted",  int'(abort_count != 0), 1);
        clr_stats();
        for (int i = 0; i < 12; i++) cycle(1);
        check("bounce_press_cnt", press_cnt, 1);
        check("bounce_latency",   press_cyc, DEB + 3);

        // Bouncing release: low 40 ns, high 20 ns, then low held.
        clr_stats();
        cycle(0); cycle(0); cycle(1);
        for (int i = 0; i < 12; i++) cycle(0);
        check("rel_bounce_cnt",   rel_cnt, 1);
        check("rel_bounce_press", press_cnt, 0);
        check("rel_bounce_clean", int'(button_clean), 0);

        // Abort counter saturation with 300 one-cycle glitches.
        async_reset("rst_sat");
        clr_stats();
        for (int i = 0; i < 300; i++) begin
            cycle(1);
            cycle(0);
        end
        for (int i = 0; i < 4; i++) cycle(0);
        check("sat_abort",    int'(abort_count), ABORT_SAT);
        check("sat_clean",    int'(button_clean), 0);
        check("sat_no_press", press_cnt, 0);

        // Randomized level runs of varying length against the model.
        for (int r = 0; r < 250; r++) begin
            lvl = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 12));
            for (int k = 0; k < len; k++) cycle(lvl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
